// File: rtl/regfile_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : regfile_sequencer
//  Purpose  : Four-state command sequencer driving an external register file.
//             Accepts LDI/MOV/ADD/SUB commands, reads up to two source
//             registers, computes the result and writes it back, keeping
//             carry/borrow and zero flags of the last retired MOV/ADD/SUB.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                      : clock, all state changes on rising edge
//    reset_n                  : asynchronous active-low reset
//    cmd_valid / cmd_ready    : command handshake (ready only when idle)
//    cmd_op                   : 0 LDI, 1 MOV, 2 ADD, 3 SUB
//    cmd_rd/cmd_rs0/cmd_rs1   : destination and source register indices
//    cmd_imm                  : immediate for LDI
//    rd0_*/rd1_*              : register-file read ports (data one cycle late)
//    wr_enable/addr/data      : register-file write port
//    done                     : one-cycle pulse when a command retires
//    flag_c / flag_z          : carry/borrow and zero flags
// ============================================================================
module regfile_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [ADDR_WIDTH-1:0] cmd_rd,
   input  logic [ADDR_WIDTH-1:0] cmd_rs0,
   input  logic [ADDR_WIDTH-1:0] cmd_rs1,
   input  logic [DATA_WIDTH-1:0] cmd_imm,
   output logic                  rd0_enable,
   output logic [ADDR_WIDTH-1:0] rd0_addr,
   input  logic [DATA_WIDTH-1:0] rd0_data,
   output logic                  rd1_enable,
   output logic [ADDR_WIDTH-1:0] rd1_addr,
   input  logic [DATA_WIDTH-1:0] rd1_data,
   output logic                  wr_enable,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  done,
   output logic                  flag_c,
   output logic                  flag_z
);

   localparam logic [1:0] C_OP_LDI = 2'd0;
   localparam logic [1:0] C_OP_MOV = 2'd1;
   localparam logic [1:0] C_OP_ADD = 2'd2;
   localparam logic [1:0] C_OP_SUB = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_EXEC  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;

   logic [1:0]              r_op;
   logic [ADDR_WIDTH-1:0]   r_rd;
   logic [ADDR_WIDTH-1:0]   r_rs0;
   logic [ADDR_WIDTH-1:0]   r_rs1;
   logic [DATA_WIDTH-1:0]   r_result;
   logic                    r_carry;
   logic                    r_flag_c;
   logic                    r_flag_z;

   logic                    w_accept;
   logic [DATA_WIDTH:0]     w_sum;
   logic [DATA_WIDTH:0]     w_diff;
   logic [DATA_WIDTH-1:0]   w_exec_result;
   logic                    w_exec_carry;

   assign w_accept = cmd_valid && (r_state == S_IDLE);

   // Zero-extended arithmetic: the top bit is the carry for ADD and, for SUB,
   // goes high exactly when the subtraction wraps, i.e. A < B (borrow).
   assign w_sum  = {1'b0, rd0_data} + {1'b0, rd1_data};
   assign w_diff = {1'b0, rd0_data} - {1'b0, rd1_data};

   always_comb begin
      w_exec_result = rd0_data;
      w_exec_carry  = 1'b0;
      case (r_op)
         C_OP_ADD: begin
            w_exec_result = w_sum[DATA_WIDTH-1:0];
            w_exec_carry  = w_sum[DATA_WIDTH];
         end
         C_OP_SUB: begin
            w_exec_result = w_diff[DATA_WIDTH-1:0];
            w_exec_carry  = w_diff[DATA_WIDTH];
         end
         default: begin
            w_exec_result = rd0_data;
            w_exec_carry  = 1'b0;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state and all port strobes; outputs are pure state decodes so a
   // reset forces them to zero without waiting for a clock edge.
   always_comb begin
      w_state_next = r_state;
      cmd_ready    = 1'b0;
      rd0_enable   = 1'b0;
      rd0_addr     = '0;
      rd1_enable   = 1'b0;
      rd1_addr     = '0;
      wr_enable    = 1'b0;
      wr_addr      = '0;
      wr_data      = '0;
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               w_state_next = (cmd_op == C_OP_LDI) ? S_WRITE : S_READ;
            end
         end
         S_READ: begin
            rd0_enable = 1'b1;
            rd0_addr   = r_rs0;
            if (r_op == C_OP_ADD || r_op == C_OP_SUB) begin
               rd1_enable = 1'b1;
               rd1_addr   = r_rs1;
            end
            w_state_next = S_EXEC;
         end
         S_EXEC: begin
            w_state_next = S_WRITE;
         end
         S_WRITE: begin
            wr_enable    = 1'b1;
            wr_addr      = r_rd;
            wr_data      = r_result;
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Command latch, result and flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_op     <= C_OP_LDI;
         r_rd     <= '0;
         r_rs0    <= '0;
         r_rs1    <= '0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_flag_c <= 1'b0;
         r_flag_z <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op     <= cmd_op;
            r_rd     <= cmd_rd;
            r_rs0    <= cmd_rs0;
            r_rs1    <= cmd_rs1;
            // LDI goes straight to WRITE, so the immediate is the result.
            r_result <= cmd_imm;
         end
         if (r_state == S_EXEC) begin
            r_result <= w_exec_result;
            r_carry  <= w_exec_carry;
         end
         if (r_state == S_WRITE && r_op != C_OP_LDI) begin
            r_flag_c <= r_carry;
            r_flag_z <= (r_result == '0);
         end
      end
   end

   assign flag_c = r_flag_c;
   assign flag_z = r_flag_z;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sequencer
//  Purpose  : Self-checking bench for regfile_sequencer. Models the external
//             register file, issues directed and random commands, predicts
//             each retirement from an architectural register/flag model and
//             compares in a separate monitor process.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sequencer;

   localparam int DW = 8;
   localparam int AW = 3;

   logic          clk;
   logic          reset_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_rd, cmd_rs0, cmd_rs1;
   logic [DW-1:0] cmd_imm;
   logic          rd0_enable, rd1_enable;
   logic [AW-1:0] rd0_addr, rd1_addr;
   logic [DW-1:0] rd0_data, rd1_data;
   logic          wr_enable;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          done;
   logic          flag_c, flag_z;

   regfile_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_rd     (cmd_rd),
      .cmd_rs0    (cmd_rs0),
      .cmd_rs1    (cmd_rs1),
      .cmd_imm    (cmd_imm),
      .rd0_enable (rd0_enable),
      .rd0_addr   (rd0_addr),
      .rd0_data   (rd0_data),
      .rd1_enable (rd1_enable),
      .rd1_addr   (rd1_addr),
      .rd1_data   (rd1_data),
      .wr_enable  (wr_enable),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .done       (done),
      .flag_c     (flag_c),
      .flag_z     (flag_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // External register file: read data appears one cycle after the strobe,
   // random garbage otherwise.
   logic [DW-1:0] rf [8];
   always @(posedge clk) begin
      rd0_data <= rd0_enable ? rf[rd0_addr] : DW'($urandom);
      rd1_data <= rd1_enable ? rf[rd1_addr] : DW'($urandom);
      if (wr_enable) rf[wr_addr] <= wr_data;
   end

   typedef struct {
      logic [1:0]    op;
      logic [AW-1:0] rd, rs0, rs1;
      logic [DW-1:0] data;
      logic          c, z;
      int            exp_cyc;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] ref_regs [8];
   logic          ref_c = 1'b0, ref_z = 1'b0;
   int            errors = 0, checks = 0;
   int            last_acc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Architectural model: applies the command to the register/flag state in
   // program order and records what the retirement must look like.
   task automatic model_push(input logic [1:0] op, input logic [AW-1:0] rd, rs0, rs1,
                             input logic [DW-1:0] imm, input int acc);
      int a, b, r;
      exp_t e;
      a = int'(ref_regs[rs0]);
      b = int'(ref_regs[rs1]);
      e.c = ref_c;
      e.z = ref_z;
      r = 0;
      case (op)
         2'd0: r = int'(imm);
         2'd1: begin r = a; e.c = 1'b0; e.z = (r == 0); end
         2'd2: begin r = (a + b) % 256; e.c = ((a + b) > 255); e.z = (r == 0); end
         default: begin r = (a - b + 256) % 256; e.c = (a < b); e.z = (r == 0); end
      endcase
      e.op = op; e.rd = rd; e.rs0 = rs0; e.rs1 = rs1;
      e.data = DW'(r);
      e.exp_cyc = acc + ((op == 2'd0) ? 0 : 2);
      ref_regs[rd] = DW'(r);
      ref_c = e.c;
      ref_z = e.z;
      sb.push_back(e);
   endtask

   // Offers a command, scrambling the fields while the sequencer is busy;
   // returns at the falling edge after acceptance.
   task automatic issue(input logic [1:0] op, input logic [AW-1:0] rd, rs0, rs1,
                        input logic [DW-1:0] imm, input bit keep);
      int w = 0;
      cmd_valid = 1'b1;
      while (!cmd_ready) begin
         cmd_op = 2'($urandom); cmd_rd = AW'($urandom);
         cmd_rs0 = AW'($urandom); cmd_rs1 = AW'($urandom); cmd_imm = DW'($urandom);
         @(negedge clk);
         w++;
         if (w > 30) begin
            check("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
         end
      end
      cmd_op = op; cmd_rd = rd; cmd_rs0 = rs0; cmd_rs1 = rs1; cmd_imm = imm;
      last_acc = cyc + 1;
      model_push(op, rd, rs0, rs1, imm, last_acc);
      @(negedge clk);
      cmd_valid = keep;
   endtask

   // Monitor
   logic          flag_pend = 1'b0, pend_c, pend_z;
   logic [AW-1:0] obs_wr_addr;
   logic [DW-1:0] obs_wr_data;
   logic          obs_c, obs_z;
   exp_t          me;

   always @(negedge clk) begin
      if (reset_n) begin
         if (flag_pend) begin
            check("flag_c", 32'(flag_c), 32'(pend_c));
            check("flag_z", 32'(flag_z), 32'(pend_z));
            obs_c = flag_c;
            obs_z = flag_z;
            flag_pend = 1'b0;
         end
         if (cmd_ready) begin
            check("idle_strobes", {28'd0, rd0_enable, rd1_enable, wr_enable, done}, 32'd0);
            check("idle_buses", {18'd0, rd0_addr, rd1_addr, wr_addr, wr_data}, 32'd0);
         end
         if (rd0_enable) begin
            if (sb.size() == 0) begin
               check("unexpected_read", 32'(rd0_enable), 32'd0);
            end else begin
               me = sb[0];
               check("rd0_addr", 32'(rd0_addr), 32'(me.rs0));
               check("rd1_enable", 32'(rd1_enable), 32'(me.op[1]));
               check("rd1_addr", 32'(rd1_addr), me.op[1] ? 32'(me.rs1) : 32'd0);
            end
         end
         if (wr_enable) begin
            if (sb.size() == 0) begin
               check("unexpected_write", 32'(wr_enable), 32'd0);
            end else begin
               me = sb.pop_front();
               check("wr_addr", 32'(wr_addr), 32'(me.rd));
               check("wr_data", 32'(wr_data), 32'(me.data));
               check("done", 32'(done), 32'd1);
               check("latency", 32'(cyc), 32'(me.exp_cyc));
               obs_wr_addr = wr_addr;
               obs_wr_data = wr_data;
               pend_c = me.c;
               pend_z = me.z;
               flag_pend = 1'b1;
            end
         end else if (done) begin
            check("done_without_write", 32'(done), 32'd0);
         end
      end
   end

   task automatic wait_retire();
      int n = 0;
      while (sb.size() != 0 || flag_pend) begin
         @(negedge clk);
         #1;
         n++;
         if (n > 20) begin
            check("retire_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
            flag_pend = 1'b0;
            return;
         end
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_ready"}, 32'(cmd_ready), 32'd1);
      check({name, "_strobes"}, {28'd0, rd0_enable, rd1_enable, wr_enable, done}, 32'd0);
      check({name, "_buses"}, {18'd0, rd0_addr, rd1_addr, wr_addr, wr_data}, 32'd0);
      check({name, "_flags"}, {30'd0, flag_c, flag_z}, 32'd0);
   endtask

   initial begin
      logic [DW-1:0] snap [8];
      int a1;
      logic [DW-1:0] init_vals [8];
      init_vals = '{8'd0, 8'd11, 8'd200, 8'd100, 8'd3, 8'd5, 8'd7, 8'd9};

      reset_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_op = '0; cmd_rd = '0; cmd_rs0 = '0; cmd_rs1 = '0; cmd_imm = '0;
      for (int i = 0; i < 8; i++) ref_regs[i] = '0;
      #1;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) issue(2'd0, AW'(i), '0, '0, init_vals[i], 1'b0);
      wait_retire();

      // ADD r1 = r2 + r3 = 200 + 100 -> 44 with carry
      issue(2'd2, 3'd1, 3'd2, 3'd3, 8'd0, 1'b0);
      wait_retire();
      check("add_data", 32'(obs_wr_data), 32'd44);
      check("add_addr", 32'(obs_wr_addr), 32'd1);
      check("add_flags", {30'd0, obs_c, obs_z}, 32'b10);

      // LDI r3 = 42 keeps the flags from the ADD
      issue(2'd0, 3'd3, 3'd0, 3'd0, 8'd42, 1'b0);
      wait_retire();
      check("ldi_data", 32'(obs_wr_data), 32'd42);
      check("ldi_addr", 32'(obs_wr_addr), 32'd3);
      check("ldi_flags", {30'd0, obs_c, obs_z}, 32'b10);

      // SUB r5 = r5 - r5 -> 0, zero
      issue(2'd3, 3'd5, 3'd5, 3'd5, 8'd0, 1'b0);
      wait_retire();
      check("sub0_data", 32'(obs_wr_data), 32'd0);
      check("sub0_flags", {30'd0, obs_c, obs_z}, 32'b01);

      // SUB r4 = 3 - 7 -> 252, borrow
      issue(2'd3, 3'd4, 3'd4, 3'd6, 8'd0, 1'b0);
      wait_retire();
      check("subb_data", 32'(obs_wr_data), 32'd252);
      check("subb_flags", {30'd0, obs_c, obs_z}, 32'b10);

      // MOV r7 = r0 (0)
      issue(2'd1, 3'd7, 3'd0, 3'd5, 8'd0, 1'b0);
      wait_retire();
      check("mov_data", 32'(obs_wr_data), 32'd0);
      check("mov_addr", 32'(obs_wr_addr), 32'd7);
      check("mov_flags", {30'd0, obs_c, obs_z}, 32'b01);

      // Held cmd_valid: back-to-back ADDs, then back-to-back LDIs
      issue(2'd2, 3'd2, 3'd1, 3'd6, 8'd0, 1'b1);
      a1 = last_acc;
      issue(2'd2, 3'd3, 3'd2, 3'd2, 8'd0, 1'b0);
      check("add_add_spacing", 32'(last_acc - a1), 32'd4);
      wait_retire();
      issue(2'd0, 3'd6, 3'd0, 3'd0, 8'd77, 1'b1);
      a1 = last_acc;
      issue(2'd0, 3'd5, 3'd0, 3'd0, 8'd0, 1'b0);
      check("ldi_ldi_spacing", 32'(last_acc - a1), 32'd2);
      wait_retire();

      // Reset during EXEC aborts the ADD for good
      snap = ref_regs;
      issue(2'd2, 3'd0, 3'd1, 3'd2, 8'd0, 1'b0);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      sb.delete();
      ref_regs = snap;
      ref_c = 1'b0;
      ref_z = 1'b0;
      @(negedge clk);
      check("abort_wr_enable", 32'(wr_enable), 32'd0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      issue(2'd0, 3'd4, 3'd0, 3'd0, 8'd99, 1'b0);
      wait_retire();
      check("post_reset_ldi_data", 32'(obs_wr_data), 32'd99);
      check("post_reset_ldi_addr", 32'(obs_wr_addr), 32'd4);
      check("post_reset_flags", {30'd0, obs_c, obs_z}, 32'd0);

      // Random traffic against the architectural model
      for (int n = 0; n < 200; n++) begin
         bit keep;
         keep = 1'($urandom);
         issue(2'($urandom), AW'($urandom), AW'($urandom), AW'($urandom), DW'($urandom), keep);
         if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      cmd_valid = 1'b0;
      wait_retire();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, register data width.
REQ-002 Parameter ADDR_WIDTH, default 3, register address width (8 registers).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  sequencer accepts a command this cycle.
REQ-007 cmd_op  input  2  operation: 0 LDI, 1 MOV, 2 ADD, 3 SUB.
REQ-008 cmd_rd / cmd_rs0 / cmd_rs1  input  ADDR_WIDTH each  destination and source register indices.
REQ-009 cmd_imm  input  DATA_WIDTH  immediate for LDI.
REQ-010 rd0_enable, rd1_enable  output  1  register-file read strobes.
REQ-011 rd0_addr, rd1_addr  output  ADDR_WIDTH  register-file read addresses.
REQ-012 rd0_data, rd1_data  input  DATA_WIDTH  register-file read data, valid one cycle after the strobe.
REQ-013 wr_enable  output  1  register-file write strobe.
REQ-014 wr_addr  output  ADDR_WIDTH; wr_data  output  DATA_WIDTH  write address and data.
REQ-015 done  output  1  one-cycle pulse, command retired.
REQ-016 flag_c, flag_z  output  1 each  carry/borrow and zero of last retired ADD/SUB/MOV.

Function
REQ-017 FSM states IDLE, READ, EXEC, WRITE; cmd_ready = 1 only in IDLE.
REQ-018 Accept on rising edge with cmd_valid & cmd_ready; latch op, rd, rs0, rs1, imm.
REQ-019 IDLE->WRITE for LDI; IDLE->READ for MOV/ADD/SUB; no transition without handshake.
REQ-020 READ (one cycle): rd0_enable=1, rd0_addr=rs0; rd1_enable=1, rd1_addr=rs1 for ADD/SUB only (0 otherwise); next EXEC.
REQ-021 EXEC (one cycle): capture rd0_data/rd1_data; compute result; next WRITE.
REQ-022 Result: LDI=imm; MOV=A; ADD=(A+B) mod 2^DATA_WIDTH, flag carry=bit DATA_WIDTH of the (DATA_WIDTH+1)-bit sum; SUB=(A-B) mod 2^DATA_WIDTH, carry=1 iff A<B (borrow).
REQ-023 MOV sets flag_c=0; zero flag = (result==0) for MOV/ADD/SUB; LDI leaves both flags unchanged.
REQ-024 WRITE (one cycle): wr_enable=1, wr_addr=rd, wr_data=result, done=1, flags update at end of cycle; next IDLE.
REQ-025 Latency: accept at edge N -> wr_enable/done high in cycle N+1 (LDI) or N+3 (others); next accept earliest edge N+2 / N+4.
REQ-026 Outside their active state, rd0/rd1/wr enables, done = 0 and addresses/wr_data = 0.
REQ-027 rs0==rs1 and rd==rs0/rs1 are legal; reads complete before the write, so sources use pre-write values.
REQ-028 cmd_* changes while busy are ignored; held cmd_valid is accepted on the first IDLE edge.

Reset
REQ-029 reset_n=0 forces immediately: state IDLE, cmd_ready=1, all enables/done=0, addresses/wr_data=0, flag_c=flag_z=0.
REQ-030 Reset in READ/EXEC/WRITE aborts the command; no wr_enable occurs after reset asserts; the aborted command is never retried.

Verification
REQ-031 LDI rd=3 imm=42 -> cycle after accept: wr_enable=1, wr_addr=3, wr_data=42, done=1; flags unchanged.
REQ-032 r2=200, r3=100, ADD rd=1 rs0=2 rs1=3 -> READ drives rd0_addr=2/rd1_addr=3; three cycles after accept wr_data=44, wr_addr=1, flag_c=1, flag_z=0.
REQ-033 r5=5, SUB rd=5 rs0=5 rs1=5 -> wr_data=0, flag_z=1, flag_c=0; r4=3, r6=7, SUB rd=4 rs0=4 rs1=6 -> wr_data=252, flag_c=1.
REQ-034 MOV rd=7 rs0=0 with r0=0 -> rd1_enable stays 0, wr_addr=7, wr_data=0, flag_z=1, flag_c=0.
REQ-035 cmd_valid held high across two ADDs -> cmd_ready low for 3 cycles between accepts; second command accepted exactly at edge N+4.
REQ-036 ADD accepted, reset_n pulsed low during EXEC -> wr_enable never asserts, outputs at reset values, next LDI executes normally.
